// File: rtl/alu_control_fsm.sv
// Multi-cycle control FSM for the RISC-V subset core: latches and decodes the
// instruction, sequences memory handshakes, write-back and PC update.
module alu_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 pcsrc,
  output logic [3:0]           estado,
  output logic                 alusrc,
  output logic [3:0]           alucontrol,
  output logic [11:0]          immediate,
  output logic                 negativo,
  output logic                 branch,
  output logic                 irwrite,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 pcwrite,
  output logic                 pcbranch,
  output logic                 halted,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);
  typedef enum logic [3:0] {
    S_RESET  = 4'b1110,
    S_FETCH  = 4'b0000,
    S_DECODE = 4'b0001,
    S_EXEC   = 4'b0101,
    S_BRANCH = 4'b0110,
    S_BR_RES = 4'b0111,
    S_MEM_RD = 4'b0010,
    S_MEM_WR = 4'b0011,
    S_WB     = 4'b0100,
    S_HALT   = 4'b1111
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic        is_lw, is_sw;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic        d_ok, d_src, d_br, d_lw, d_sw, d_ebreak;
  logic [3:0]  d_ctl;
  logic [11:0] d_raw, d_mag;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  always_comb begin
    d_ok     = 1'b0;
    d_src    = 1'b0;
    d_br     = 1'b0;
    d_lw     = 1'b0;
    d_sw     = 1'b0;
    d_ctl    = 4'b0000;
    d_raw    = 12'h000;
    d_ebreak = (ir == 32'h0010_0073);
    case (opc)
      7'b0110011: begin
        d_ok = 1'b1;
        case (f3)
          3'b000: begin
            if (f7 == 7'b0000000)      d_ctl = 4'b0010;
            else if (f7 == 7'b0100000) d_ctl = 4'b0110;
            else                       d_ok  = 1'b0;
          end
          3'b111: d_ctl = 4'b0000;
          3'b110: d_ctl = 4'b0001;
          3'b100: d_ctl = 4'b0100;
          3'b101: begin
            if (f7 == 7'b0000000) d_ctl = 4'b0101;
            else                  d_ok  = 1'b0;
          end
          default: d_ok = 1'b0;
        endcase
      end
      7'b0010011: if (f3 == 3'b000) begin
        d_ok = 1'b1; d_src = 1'b1; d_ctl = 4'b0011; d_raw = ir[31:20];
      end
      7'b0000011: if (f3 == 3'b010) begin
        d_ok = 1'b1; d_src = 1'b1; d_ctl = 4'b0010; d_lw = 1'b1; d_raw = ir[31:20];
      end
      7'b0100011: if (f3 == 3'b010) begin
        d_ok = 1'b1; d_src = 1'b1; d_ctl = 4'b0010; d_sw = 1'b1;
        d_raw = {ir[31:25], ir[11:7]};
      end
      7'b1100011: if (f3 == 3'b000 || f3 == 3'b001) begin
        d_ok  = 1'b1; d_src = 1'b1; d_br = 1'b1;
        d_ctl = f3[0] ? 4'b1111 : 4'b0110;
        d_raw = {ir[31], ir[7], ir[30:25], ir[11:8]};
      end
      default: ;
    endcase
  end

  // Magnitude of the 12-bit value; 0x800 negates to itself (2048 unsigned).
  assign d_mag = d_raw[11] ? (~d_raw + 12'd1) : d_raw;

  assign estado   = state;
  assign irwrite  = (state == S_FETCH) && mem_ready;
  assign memread  = (state == S_FETCH) || (state == S_MEM_RD);
  assign memwrite = (state == S_MEM_WR);
  assign regwrite = (state == S_WB);
  assign memtoreg = (state == S_WB) && is_lw;
  assign pcwrite  = (state == S_WB) || ((state == S_MEM_WR) && mem_ready)
                 || ((state == S_BR_RES) && !pcsrc);
  assign pcbranch = (state == S_BR_RES) && pcsrc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      ir         <= '0;
      alusrc     <= 1'b0;
      alucontrol <= '0;
      immediate  <= '0;
      negativo   <= 1'b0;
      branch     <= 1'b0;
      is_lw      <= 1'b0;
      is_sw      <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      instret    <= '0;
    end else begin
      if (pcwrite || pcbranch) instret <= instret + INSTRET_W'(1);
      case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: if (mem_ready) begin
          ir    <= instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          alusrc     <= d_src;
          alucontrol <= d_ctl;
          immediate  <= d_mag;
          negativo   <= d_raw[11];
          branch     <= d_br;
          is_lw      <= d_lw;
          is_sw      <= d_sw;
          if (d_ebreak) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (!d_ok) begin
            illegal <= 1'b1;
            state   <= S_HALT;
          end else begin
            state <= d_br ? S_BRANCH : S_EXEC;
          end
        end
        S_EXEC:   state <= is_lw ? S_MEM_RD : (is_sw ? S_MEM_WR : S_WB);
        S_MEM_RD: if (mem_ready) state <= S_WB;
        S_MEM_WR: if (mem_ready) state <= S_FETCH;
        S_BRANCH: state <= S_BR_RES;
        S_BR_RES: state <= S_FETCH;
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_control_fsm.sv
// Directed bench for alu_control_fsm: per-cycle state/strobe tables per scenario.
module tb_alu_control_fsm;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0, pcsrc = 1'b0;
  logic [3:0]  estado, alucontrol;
  logic        alusrc, negativo, branch;
  logic [11:0] immediate;
  logic        irwrite, memread, memwrite, memtoreg, regwrite, pcwrite, pcbranch, halted, illegal;
  logic [31:0] instret;
  logic [8:0]  strb;
  logic [31:0] exp_ret;
  int vectors = 0, miscompares = 0;

  alu_control_fsm #(.INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .pcsrc(pcsrc),
    .estado(estado), .alusrc(alusrc), .alucontrol(alucontrol), .immediate(immediate),
    .negativo(negativo), .branch(branch), .irwrite(irwrite), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite), .pcwrite(pcwrite),
    .pcbranch(pcbranch), .halted(halted), .illegal(illegal), .instret(instret)
  );

  // {irwrite, memread, memwrite, memtoreg, regwrite, pcwrite, pcbranch, halted, illegal}
  assign strb = {irwrite, memread, memwrite, memtoreg, regwrite, pcwrite, pcbranch, halted, illegal};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({estado, alusrc, alucontrol, immediate, negativo, branch, strb, instret} !==
        {4'b1110, 1'b0, 4'b0, 12'b0, 1'b0, 1'b0, 9'b0, 32'b0}) begin
      miscompares++;
      $display("FAIL reset_state: estado=%b strobes=%b alu=%b imm=%h instret=%0d, want 1110/0/0/0/0",
               estado, strb, alucontrol, immediate, instret);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (estado !== 4'b1110) begin
      miscompares++; $display("FAIL reset_hold: estado=%b want 1110", estado);
    end
    step();
    vectors++;
    if (estado !== 4'b0000) begin
      miscompares++; $display("FAIL first_fetch: estado=%b want 0000", estado);
    end
    exp_ret = 0;
  endtask

  task automatic test_add();
    logic [3:0] st[4];
    logic [8:0] sb[4];
    st = '{4'b0000, 4'b0001, 4'b0101, 4'b0100};
    sb = '{9'b110000000, 9'b0, 9'b0, 9'b000011000};
    instr = 32'h002081B3; mem_ready = 1'b1; pcsrc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (estado !== st[i] || strb !== sb[i]) begin
        miscompares++;
        $display("FAIL add c%0d: estado=%b strobes=%b, want %b %b", i, estado, strb, st[i], sb[i]);
      end
      if (i >= 2) begin
        vectors++;
        if ({alucontrol, alusrc} !== 5'b0010_0) begin
          miscompares++; $display("FAIL add_decode c%0d: alu=%b src=%b, want 0010 0", i, alucontrol, alusrc);
        end
      end
      step();
    end
    exp_ret++;
    vectors++;
    if (instret !== exp_ret || estado !== 4'b0000) begin
      miscompares++; $display("FAIL add_retire: instret=%0d estado=%b, want %0d 0000", instret, estado, exp_ret);
    end
  endtask

  task automatic test_imm();
    // addi x1,x0,-2048 then lw x1,-4(x2)
    instr = 32'h80000093; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 2) begin
        vectors++;
        if ({alucontrol, alusrc, negativo, immediate} !== {4'b0011, 1'b1, 1'b1, 12'h800}) begin
          miscompares++;
          $display("FAIL addi_imm: alu=%b src=%b neg=%b imm=%h, want 0011 1 1 800", alucontrol, alusrc, negativo, immediate);
        end
      end
      step();
    end
    instr = 32'hFFC12083;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i == 2) begin
        vectors++;
        if ({alucontrol, alusrc, negativo, immediate} !== {4'b0010, 1'b1, 1'b1, 12'h004}) begin
          miscompares++;
          $display("FAIL lw_imm: alu=%b src=%b neg=%b imm=%h, want 0010 1 1 004", alucontrol, alusrc, negativo, immediate);
        end
      end
      step();
    end
    exp_ret += 2;
    vectors++;
    if (instret !== exp_ret || estado !== 4'b0000) begin
      miscompares++; $display("FAIL imm_retire: instret=%0d estado=%b, want %0d 0000", instret, estado, exp_ret);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] st[8];
    logic [8:0] sb[8];
    logic       mr[8];
    st = '{4'b0000, 4'b0001, 4'b0101, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    sb = '{9'b110000000, 9'b0, 9'b0, 9'b010000000, 9'b010000000, 9'b010000000, 9'b010000000, 9'b000111000};
    mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    instr = 32'h00812083;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      vectors++;
      if (estado !== st[i] || strb !== sb[i]) begin
        miscompares++;
        $display("FAIL lw_stall c%0d: estado=%b strobes=%b, want %b %b", i, estado, strb, st[i], sb[i]);
      end
      if (i >= 2) begin
        vectors++;
        if ({alucontrol, alusrc, immediate, negativo} !== {4'b0010, 1'b1, 12'd8, 1'b0}) begin
          miscompares++;
          $display("FAIL lw_stable c%0d: alu=%b src=%b imm=%h neg=%b, want 0010 1 008 0", i, alucontrol, alusrc, immediate, negativo);
        end
      end
      step();
    end
    exp_ret++;
    vectors++;
    if (instret !== exp_ret || estado !== 4'b0000) begin
      miscompares++; $display("FAIL lw_retire: instret=%0d estado=%b, want %0d 0000", instret, estado, exp_ret);
    end
  endtask

  task automatic test_store();
    logic [3:0] st[5];
    logic [8:0] sb[5];
    logic       mr[5];
    st = '{4'b0000, 4'b0001, 4'b0101, 4'b0011, 4'b0011};
    sb = '{9'b110000000, 9'b0, 9'b0, 9'b001000000, 9'b001001000};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    instr = 32'h0020A623;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      #1;
      vectors++;
      if (estado !== st[i] || strb !== sb[i]) begin
        miscompares++;
        $display("FAIL sw c%0d: estado=%b strobes=%b, want %b %b", i, estado, strb, st[i], sb[i]);
      end
      if (i == 3) begin
        vectors++;
        if ({alucontrol, alusrc, immediate, negativo} !== {4'b0010, 1'b1, 12'd12, 1'b0}) begin
          miscompares++;
          $display("FAIL sw_imm: alu=%b src=%b imm=%h neg=%b, want 0010 1 00c 0", alucontrol, alusrc, immediate, negativo);
        end
      end
      step();
    end
    exp_ret++;
    vectors++;
    if (instret !== exp_ret || estado !== 4'b0000) begin
      miscompares++; $display("FAIL sw_retire: instret=%0d estado=%b, want %0d 0000", instret, estado, exp_ret);
    end
  endtask

  task automatic test_branch();
    logic [3:0] st[4];
    logic [8:0] sb[4];
    logic       ps[4];
    // beq x1,x2,+8 taken
    st = '{4'b0000, 4'b0001, 4'b0110, 4'b0111};
    sb = '{9'b110000000, 9'b0, 9'b0, 9'b000000100};
    ps = '{1'b0, 1'b1, 1'b0, 1'b1};
    instr = 32'h00208463; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pcsrc = ps[i];
      #1;
      vectors++;
      if (estado !== st[i] || strb !== sb[i]) begin
        miscompares++;
        $display("FAIL beq c%0d: estado=%b strobes=%b, want %b %b", i, estado, strb, st[i], sb[i]);
      end
      if (i >= 2) begin
        vectors++;
        if ({alucontrol, alusrc, branch, immediate, negativo} !== {4'b0110, 1'b1, 1'b1, 12'd4, 1'b0}) begin
          miscompares++;
          $display("FAIL beq_decode c%0d: alu=%b src=%b br=%b imm=%h neg=%b, want 0110 1 1 004 0", i, alucontrol, alusrc, branch, immediate, negativo);
        end
      end
      step();
    end
    // bne x1,x2,-4 not taken; pcsrc high outside BR_RES must be ignored
    sb = '{9'b110000000, 9'b0, 9'b0, 9'b000001000};
    ps = '{1'b1, 1'b1, 1'b1, 1'b0};
    instr = 32'hFE209EE3;
    for (int i = 0; i < 4; i++) begin
      pcsrc = ps[i];
      #1;
      vectors++;
      if (estado !== st[i] || strb !== sb[i]) begin
        miscompares++;
        $display("FAIL bne c%0d: estado=%b strobes=%b, want %b %b", i, estado, strb, st[i], sb[i]);
      end
      if (i >= 2) begin
        vectors++;
        if ({alucontrol, alusrc, branch, immediate, negativo} !== {4'b1111, 1'b1, 1'b1, 12'd2, 1'b1}) begin
          miscompares++;
          $display("FAIL bne_decode c%0d: alu=%b src=%b br=%b imm=%h neg=%b, want 1111 1 1 002 1", i, alucontrol, alusrc, branch, immediate, negativo);
        end
      end
      step();
    end
    pcsrc = 1'b0;
    exp_ret += 2;
    vectors++;
    if (instret !== exp_ret || estado !== 4'b0000) begin
      miscompares++; $display("FAIL br_retire: instret=%0d estado=%b, want %0d 0000", instret, estado, exp_ret);
    end
  endtask

  task automatic test_halt();
    logic [3:0] st[5];
    logic [8:0] sb[5];
    logic       mr[5];
    st = '{4'b0000, 4'b0001, 4'b1111, 4'b1111, 4'b1111};
    sb = '{9'b110000000, 9'b0, 9'b000000001, 9'b000000001, 9'b000000001};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    instr = 32'hFFFFFFFF; pcsrc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      #1;
      vectors++;
      if (estado !== st[i] || strb !== sb[i] || instret !== exp_ret) begin
        miscompares++;
        $display("FAIL illegal c%0d: estado=%b strobes=%b instret=%0d, want %b %b %0d", i, estado, strb, instret, st[i], sb[i], exp_ret);
      end
      step();
    end
    pcsrc = 1'b0; mem_ready = 1'b1;
    rst_n = 1'b0; #1;
    vectors++;
    if (strb !== 9'b0 || estado !== 4'b1110 || instret !== 32'd0) begin
      miscompares++; $display("FAIL illegal_clear: strobes=%b estado=%b instret=%0d, want 0 1110 0", strb, estado, instret);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    step();
    exp_ret = 0;
    sb = '{9'b110000000, 9'b0, 9'b000000010, 9'b000000010, 9'b000000010};
    instr = 32'h00100073;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (estado !== st[i] || strb !== sb[i] || instret !== exp_ret) begin
        miscompares++;
        $display("FAIL ebreak c%0d: estado=%b strobes=%b instret=%0d, want %b %b %0d", i, estado, strb, instret, st[i], sb[i], exp_ret);
      end
      step();
    end
    rst_n = 1'b0; #1;
    vectors++;
    if (strb !== 9'b0 || estado !== 4'b1110) begin
      miscompares++; $display("FAIL halted_clear: strobes=%b estado=%b, want 0 1110", strb, estado);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_store();
    instr = 32'h0020A623; mem_ready = 1'b1;
    step(); step(); step();  // FETCH, DECODE, EXEC
    mem_ready = 1'b0;
    step();                  // second stalled MEM_WR cycle
    #1;
    vectors++;
    if (estado !== 4'b0011 || memwrite !== 1'b1 || pcwrite !== 1'b0) begin
      miscompares++; $display("FAIL mw_stall: estado=%b memwrite=%b pcwrite=%b, want 0011 1 0", estado, memwrite, pcwrite);
    end
    rst_n = 1'b0; #1;
    vectors++;
    if ({estado, alusrc, alucontrol, immediate, negativo, branch, strb, instret} !==
        {4'b1110, 1'b0, 4'b0, 12'b0, 1'b0, 1'b0, 9'b0, 32'b0}) begin
      miscompares++;
      $display("FAIL mid_reset: estado=%b strobes=%b alu=%b imm=%h instret=%0d, want 1110/0/0/0/0",
               estado, strb, alucontrol, immediate, instret);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    vectors++;
    if (estado !== 4'b1110 || memwrite !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_hold: estado=%b memwrite=%b, want 1110 0", estado, memwrite);
    end
    step();
    vectors++;
    if (estado !== 4'b0000 || instret !== 32'd0 || pcwrite !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_fetch: estado=%b instret=%0d pcwrite=%b, want 0000 0 0", estado, instret, pcwrite);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_lw_stall();
    test_store();
    test_branch();
    test_halt();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule

// File: doc/alu_control_fsm.md
# alu_control_fsm

Multi-cycle control state machine that sequences the datapath of the 32-bit RISC-V subset core around the shared ALU. It latches and decodes each fetched instruction and drives the ALU state code (`estado`), ALU operation/source selects, and the immediate magnitude and sign. It also sequences the instruction/data memory handshake, register write-back and PC update. It sits between the instruction register/memory interface and the ALU/register file.

## Interface

Parameters:
- `INSTRET_W`, 32, width of retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction word from memory; valid when `mem_ready`=1 in FETCH.
- `mem_ready`  in  1  memory completion for fetch/load/store.
- `pcsrc`  in  1  branch-taken flag from ALU (`aluresult1 & branch`).
- `estado`  out  4  current state code.
- `alusrc`  out  1  1 = ALU uses immediate.
- `alucontrol`  out  4  ALU operation code.
- `immediate`  out  12  immediate magnitude (unsigned).
- `negativo`  out  1  immediate sign.
- `branch`  out  1  instruction is beq/bne.
- `irwrite`, `memread`, `memwrite`, `memtoreg`, `regwrite`  out  1 each  datapath strobes.
- `pcwrite`  out  1  PC ← PC+4.
- `pcbranch`  out  1  PC ← PC + sign-extended B-immediate.
- `halted`, `illegal`  out  1 each  sticky stop flags.
- `instret`  out  INSTRET_W  retired instruction count.

## Operation

- States (`estado` code): RESET 1110, FETCH 0000, DECODE 0001, EXEC 0101, BRANCH 0110, BR_RES 0111, MEM_RD 0010, MEM_WR 0011, WB 0100, HALT 1111.
- Transitions:
  - RESET → FETCH.
  - FETCH holds until `mem_ready`, then captures `instr` into the IR (`irwrite`=1 that cycle) and goes to DECODE.
  - DECODE → BRANCH for beq/bne.
  - DECODE → HALT for ebreak (0x00100073), setting `halted`.
  - DECODE → HALT for an illegal instruction, setting `illegal`.
  - DECODE → EXEC otherwise.
  - EXEC → MEM_RD for lw, → MEM_WR for sw, → WB otherwise.
  - MEM_RD holds until `mem_ready`, then → WB.
  - MEM_WR holds until `mem_ready`, then → FETCH.
  - BRANCH → BR_RES (one wait cycle for the registered compare); BR_RES → FETCH.
  - WB → FETCH.
  - HALT is exited only by reset.
- Decode, latched in DECODE, valid from EXEC/BRANCH onward. Each entry is opcode/funct3/funct7 → alucontrol, alusrc:
  - R-type 0110011, alusrc=0:
    - add 000/0000000 → 0010.
    - sub 000/0100000 → 0110.
    - and 111 → 0000.
    - or 110 → 0001.
    - xor 100 → 0100.
    - srl 101/0000000 → 0101.
  - addi 0010011/000 → 0011, alusrc=1.
  - lw 0000011/010 and sw 0100011/010 → 0010, alusrc=1.
  - beq 1100011/000 → 0110, bne 1100011/001 → 1111; both alusrc=1, branch=1.
  - Any other encoding is illegal.
- Immediate selection: I-type instr[31:20]; S-type {instr[31:25],instr[11:7]}; B-type {instr[31],instr[7],instr[30:25],instr[11:8]}.
- Immediate output: `negativo` = instr[31]. `immediate` = value if non-negative, otherwise its 12-bit two's-complement negation. Raw value 0x800 yields magnitude 0x800, which is 2048 unsigned.
- Strobes (Moore, decoded from state and latched fields):
  - `memread` in FETCH and MEM_RD.
  - `memwrite` in MEM_WR.
  - `regwrite` in WB.
  - `memtoreg` in WB for lw.
  - `pcwrite` in WB, in MEM_WR when `mem_ready`, and in BR_RES when `pcsrc`=0.
  - `pcbranch` in BR_RES when `pcsrc`=1.
- Exactly one `pcwrite` or `pcbranch` pulse per retired instruction. `instret` increments on that same cycle and wraps modulo 2^INSTRET_W.

## Timing

- Reset (async assert, any state, mid-instruction included):
  - State goes to RESET.
  - All 1-bit outputs read 0.
  - `estado`=1110; `alucontrol`, `immediate` and `instret` read 0.
  - No pending memory write or PC update survives reset.
- First FETCH occurs one cycle after `rst_n` deasserts.
- Latency with `mem_ready` held 1:
  - R-type/addi: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 4 cycles (FETCH, DECODE, BRANCH, BR_RES).
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. The strobe stays asserted and all other outputs stay stable.
- `pcsrc` is sampled only in BR_RES; its value in any other state is ignored.
- `alucontrol`, `alusrc`, `immediate` and `negativo` are stable from EXEC/BRANCH through the instruction's last state.
- `halted`/`illegal` assert on entry to HALT. In HALT all strobes are 0 and `instret` is frozen.

## Test plan

- Reset mid-MEM_WR (`mem_ready`=0), then release → `memwrite` drops immediately, `estado`=1110 then 0000, `instret`=0.
- add x3,x1,x2 (0x002081B3) with `mem_ready`=1 → states 0000, 0001, 0101, 0100; `alucontrol`=0010, `alusrc`=0; `regwrite`+`pcwrite` in the 4th cycle; `instret`=1.
- addi x1,x0,-2048 (0x80000093) → `alucontrol`=0011, `negativo`=1, `immediate`=0x800. lw with imm −4 → `immediate`=4, `negativo`=1.
- lw with `mem_ready` low for 3 cycles in MEM_RD → 8 total cycles; `memread` held 4 cycles; `memtoreg`=1 in WB.
- beq with `pcsrc`=1 in BR_RES → `pcbranch`=1, `pcwrite`=0. bne with `pcsrc`=0 → `pcwrite`=1, `alucontrol`=1111, `branch`=1.
- Fetch 0xFFFFFFFF → HALT (1111), `illegal`=1, no PC pulse. Fetch 0x00100073 → `halted`=1, `illegal`=0. Both flags clear only on `rst_n`.
